// File: rtl/sort_stream_if.sv
// sort_stream_if: start/done handshake plus source BRAM, sorter and destination BRAM signals
interface sort_stream_if #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8
);
  logic                 start, busy, done, sort_err;
  logic [ADDRWIDTH-1:0] src_addr, dst_addr;
  logic [DATAWIDTH-1:0] src_data, srt_in, srt_out, dst_data;
  logic                 srt_load, srt_enable, dst_we;
  modport master (
    input  start, src_data, srt_out,
    output busy, done, sort_err, src_addr, srt_load, srt_enable, srt_in, dst_we, dst_addr, dst_data
  );
  modport slave (
    output start, src_data, srt_out,
    input  busy, done, sort_err, src_addr, srt_load, srt_enable, srt_in, dst_we, dst_addr, dst_data
  );
endinterface

// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: streams a block from source BRAM through an odd-even sorter into destination BRAM
module sort_stream_ctrl #(
  parameter int ADDRWIDTH   = 4,
  parameter int DATAWIDTH   = 8,
  parameter int SORT_CYCLES = 16
) (
  input logic           clk,
  input logic           rst_n,
  sort_stream_if.master bus
);
  localparam int SIZE = 2 ** ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] RD_LAST = (ADDRWIDTH + 1)'(SIZE);
  localparam logic [ADDRWIDTH:0] UL_LAST = (ADDRWIDTH + 1)'(SIZE - 1);
  localparam logic [15:0]        PH_LAST = 16'(SORT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, READ, SORT, UNLOAD, DRAIN, DONE} state_t;
  state_t               r_state, w_next;
  logic [ADDRWIDTH:0]   r_cnt;
  logic [15:0]          r_ph;
  logic                 r_dst_we, r_err, w_load, w_unload;
  logic [ADDRWIDTH-1:0] r_dst_addr;
  logic [DATAWIDTH-1:0] r_dst_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? READ : IDLE;
      READ:    w_next = r_cnt == RD_LAST ? SORT : READ;
      SORT:    w_next = r_ph == PH_LAST ? UNLOAD : SORT;
      UNLOAD:  w_next = r_cnt == UL_LAST ? DRAIN : UNLOAD;
      DRAIN:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // first READ cycle only issues address 0; loads follow one cycle behind the BRAM
  assign w_load   = r_state == READ && r_cnt != '0;
  assign w_unload = r_state == UNLOAD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt      <= '0;
      r_ph       <= '0;
      r_dst_we   <= 1'b0;
      r_dst_addr <= '0;
      r_dst_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_cnt    <= (r_state == READ || w_unload) && w_next == r_state ? r_cnt + 1'b1 : '0;
      r_ph     <= r_state == SORT ? r_ph + 1'b1 : '0;
      r_dst_we <= w_unload;
      if (w_unload) begin
        r_dst_addr <= r_cnt[ADDRWIDTH-1:0];
        r_dst_data <= bus.srt_out;
      end
      // r_dst_data still holds the previous unloaded word when compared here
      r_err <= r_state == IDLE && bus.start ? 1'b0
             : r_err | (w_unload && r_cnt != '0 && bus.srt_out < r_dst_data);
    end
  always_comb begin
    bus.busy       = r_state != IDLE;
    bus.done       = r_state == DONE;
    bus.sort_err   = r_err;
    bus.src_addr   = r_state == READ && r_cnt != RD_LAST ? r_cnt[ADDRWIDTH-1:0] : {ADDRWIDTH{r_state == READ}};
    bus.srt_load   = w_load;
    bus.srt_in     = w_load ? bus.src_data : '0;
    bus.srt_enable = w_unload;
    bus.dst_we     = r_dst_we;
    bus.dst_addr   = r_dst_addr;
    bus.dst_data   = r_dst_data;
  end
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// tb_sort_stream_ctrl: two controllers (full and short sort) with BRAM and sorter models, cycle-checked against a run timeline
module tb_sort_stream_ctrl;
  localparam int AW = 4, DW = 8, N = 16;
  typedef logic [DW-1:0] arr_t [N];
  logic       clk = 0, rst_n = 1;
  logic [1:0] st = '0;
  logic [1:0] dn, er;
  int         errors = 0, checks = 0;
  arr_t       src_mem;
  always #5 clk = ~clk;

  function automatic arr_t phase(arr_t a, logic odd);
    arr_t t = a;
    for (int i = int'(odd); i + 1 < N; i += 2)
      if (a[i] > a[i+1]) begin t[i] = a[i+1]; t[i+1] = a[i]; end
    return t;
  endfunction

  function automatic arr_t sort_model(arr_t a, int sc);
    arr_t t = a;
    for (int p = 0; p < sc; p++) t = phase(t, p[0]);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  sort_stream_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bi [2] ();

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int SC = g == 0 ? 16 : 2;
    localparam int U0 = N + 2 + SC;
    localparam int DN = U0 + N + 1;
    arr_t          el, exp_w, src_s, dst;
    logic [AW-1:0] idx;
    logic          par;
    logic          err = 0;
    int            n = 0;
    int            wr = 0;
    sort_stream_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .SORT_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bi[g])
    );
    assign bi[g].start   = st[g];
    assign bi[g].srt_out = el[idx];
    assign dn[g]         = bi[g].done;
    assign er[g]         = bi[g].sort_err;
    always @(posedge clk) bi[g].src_data <= src_mem[bi[g].src_addr];
    always @(posedge clk) begin
      if (bi[g].dst_we) dst[bi[g].dst_addr] <= bi[g].dst_data;
      wr <= (n == 0 && st[g]) ? 0 : wr + int'(bi[g].dst_we);
    end
    // odd-even transposition sorter: strobes index its array, otherwise one phase per cycle
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin idx <= '0; par <= 1'b0; end
      else if (bi[g].srt_load) begin el[idx] <= bi[g].srt_in; idx <= idx + 1'b1; par <= 1'b0; end
      else if (bi[g].srt_enable) idx <= idx + 1'b1;
      else begin el <= phase(el, par); par <= ~par; end
    // run timeline: n is the cycle number within a run, 0 when idle
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin n <= 0; err <= 1'b0; end
      else begin
        n <= n == 0 ? int'(st[g]) : n == DN ? 0 : n + 1;
        if (n == 0 && st[g]) begin
          err   <= 1'b0;
          exp_w <= sort_model(src_mem, SC);
          src_s <= src_mem;
        end else if (n > U0 && n < U0 + N && exp_w[n-U0] < exp_w[n-U0-1]) err <= 1'b1;
      end
    always @(negedge clk) begin
      logic ld, we;
      ld = n >= 2 && n <= N + 1;
      we = n > U0 && n <= U0 + N;
      chk($sformatf("i%0d busy n=%0d", g, n), bi[g].busy, n != 0);
      chk($sformatf("i%0d done n=%0d", g, n), bi[g].done, n == DN);
      chk($sformatf("i%0d srt_load n=%0d", g, n), bi[g].srt_load, ld);
      chk($sformatf("i%0d srt_in n=%0d", g, n), bi[g].srt_in, ld ? src_s[n-2] : 8'h0);
      chk($sformatf("i%0d src_addr n=%0d", g, n), bi[g].src_addr,
          n >= 1 && n <= N ? n - 1 : n == N + 1 ? N - 1 : 0);
      chk($sformatf("i%0d srt_enable n=%0d", g, n), bi[g].srt_enable, n >= U0 && n < U0 + N);
      chk($sformatf("i%0d load_enable_excl n=%0d", g, n), bi[g].srt_load & bi[g].srt_enable, 0);
      chk($sformatf("i%0d dst_we n=%0d", g, n), bi[g].dst_we, we);
      chk($sformatf("i%0d sort_err n=%0d", g, n), bi[g].sort_err, err);
      if (we) begin
        chk($sformatf("i%0d dst_addr n=%0d", g, n), bi[g].dst_addr, n - U0 - 1);
        chk($sformatf("i%0d dst_data n=%0d", g, n), bi[g].dst_data, exp_w[n-U0-1]);
      end
    end
  end

  task automatic run(input int g, output int c);
    st[g] = 1'b1;
    @(posedge clk); #1;
    st[g] = 1'b0;
    c = 1;
    while (!dn[g] && c < 300) begin @(posedge clk); #1; c++; end
    @(posedge clk); #1;
  endtask

  initial begin
    int c, d, fd;
    #1 rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_mem[i] = 8'(15 - i);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, c);
    chk("t1 done cycle", c, 51);
    for (int k = 0; k < N; k++) chk($sformatf("t1 dst[%0d]", k), gi[0].dst[k], k);
    chk("t1 sort_err", er[0], 0);
    for (int i = 0; i < N; i++) src_mem[i] = 8'(8'h10 + i);
    run(0, c);
    chk("t2 done cycle", c, 51);
    chk("t2 writes", gi[0].wr, 16);
    for (int k = 0; k < N; k++) chk($sformatf("t2 dst[%0d]", k), gi[0].dst[k], 8'h10 + k);
    chk("t2 sort_err", er[0], 0);
    for (int i = 0; i < N; i++) src_mem[i] = 8'hAA;
    run(0, c);
    for (int k = 0; k < N; k++) chk($sformatf("t3a dst[%0d]", k), gi[0].dst[k], 8'hAA);
    for (int i = 0; i < N; i++) src_mem[i] = i % 4 < 2 ? 8'd3 : 8'd1;
    run(0, c);
    for (int k = 0; k < N; k++) chk($sformatf("t3b dst[%0d]", k), gi[0].dst[k], k < 8 ? 1 : 3);
    chk("t3 sort_err", er[0], 0);
    for (int i = 0; i < N; i++) src_mem[i] = 8'(15 - i);
    run(1, c);
    chk("t4 done cycle", c, 37);
    chk("t4 sort_err", er[1], 1);
    chk("t4 dst[0]", gi[1].dst[0], 14);
    chk("t4 dst[1]", gi[1].dst[1], 12);
    chk("t4 dst[14]", gi[1].dst[14], 3);
    chk("t4 dst[15]", gi[1].dst[15], 1);
    for (int i = 0; i < N; i++) src_mem[i] = 8'(8'h10 + i);
    st[1] = 1'b1;
    @(posedge clk); #1;
    st[1] = 1'b0;
    chk("t4 sort_err cleared", er[1], 0);
    repeat (40) begin @(posedge clk); #1; end
    chk("t4 rerun sort_err", er[1], 0);
    for (int i = 0; i < N; i++) src_mem[i] = 8'(15 - i);
    st[0] = 1'b1;
    @(posedge clk); #1;
    d = 0; fd = 0;
    for (int k = 1; k <= 60; k++) begin
      st[0] = k == 5 || k == 40;
      if (dn[0]) begin d++; fd = k; end
      @(posedge clk); #1;
    end
    st[0] = 1'b0;
    chk("t5 pulse done count", d, 1);
    chk("t5 pulse done cycle", fd, 51);
    st[0] = 1'b1;
    @(posedge clk); #1;
    d = 0; fd = 0;
    for (int k = 1; k <= 120; k++) begin
      st[0] = k < 60;
      if (dn[0]) begin d++; fd = k; end
      @(posedge clk); #1;
    end
    chk("t5 held done count", d, 2);
    chk("t5 held second done", fd, 103);
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (24) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6 busy", bi[0].busy, 0);
    chk("t6 done", bi[0].done, 0);
    chk("t6 dst_we", bi[0].dst_we, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, c);
    chk("t6 done cycle", c, 51);
    for (int k = 0; k < N; k++) chk($sformatf("t6 dst[%0d]", k), gi[0].dst[k], k);
    chk("t6 sort_err", er[0], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
